// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw asynchronous input into a clean level, with registered
// rise/fall strobes and a saturating count of rejected glitches.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                a_i,
    output logic                level_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [GLITCH_W-1:0]    glitch_q, glitch_d;
    logic                   s;

    // Plain shift chain; stage 0 is the only flop that sees the raw input.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], a_i};
    assign s      = sync_q[SYNC_STAGES-1];

    always_comb begin
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;

        if (s != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (cnt_q != '0) begin
            // Input fell back before the count completed: a rejected glitch.
            cnt_d = '0;
            if (glitch_q != '1) begin
                glitch_d = glitch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
            glitch_q <= '0;
        end else begin
            sync_q   <= sync_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed self-checking bench for input_debouncer at default parameters.
module tb_input_debouncer;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    input_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .GLITCH_W       (8)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .a_i         (a),
        .level_o     (level),
        .rise_o      (rise),
        .fall_o      (fall),
        .glitch_cnt_o(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle so outputs reflect that edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic saw_level;
        rst_n = 1'b0;
        a     = 1'b1;

        // Reset with a = 1
        tick();
        tick();
        check("reset_level", 32'(level), 32'd0);
        check("reset_rise", 32'(rise), 32'd0);
        check("reset_fall", 32'(fall), 32'd0);
        check("reset_glitch", 32'(glitch_cnt), 32'd0);

        rst_n = 1'b1;
        a     = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("idle_level", 32'(level), 32'd0);

        // Clean rise: strobe after the sixth edge counting E
        a = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rise_rise_%0d", k), 32'(rise), 32'(k == 5));
            check($sformatf("rise_level_%0d", k), 32'(level), 32'(k >= 5));
            check($sformatf("rise_fall_%0d", k), 32'(fall), 32'd0);
        end

        // Clean fall
        a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("fall_fall_%0d", k), 32'(fall), 32'(k == 5));
            check($sformatf("fall_level_%0d", k), 32'(level), 32'(k < 5));
            check($sformatf("fall_rise_%0d", k), 32'(rise), 32'd0);
        end
        check("fall_glitch", 32'(glitch_cnt), 32'd0);

        // Bounce 1,1,0,0,0,0,0,0: rejected, counted two edges after a returns to 0
        for (int k = 0; k < 8; k++) begin
            a = (k < 2) ? 1'b1 : 1'b0;
            tick();
            check($sformatf("bounce_level_%0d", k), 32'(level), 32'd0);
            check($sformatf("bounce_rise_%0d", k), 32'(rise), 32'd0);
            check($sformatf("bounce_glitch_%0d", k), 32'(glitch_cnt), 32'(k >= 4));
        end

        // Saturation: 300 two-cycle pulses separated by 6 zero cycles
        saw_level = 1'b0;
        for (int p = 0; p < 300; p++) begin
            for (int k = 0; k < 8; k++) begin
                a = (k < 2) ? 1'b1 : 1'b0;
                tick();
                saw_level = saw_level | level | rise;
            end
            if (p == 252) check("sat_glitch_254", 32'(glitch_cnt), 32'd254);
            if (p == 253) check("sat_glitch_255", 32'(glitch_cnt), 32'd255);
        end
        check("sat_glitch_final", 32'(glitch_cnt), 32'd255);
        check("sat_level_never", 32'(saw_level), 32'd0);

        // Reset mid-count
        a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("midrst_pre_rise_%0d", k), 32'(rise), 32'd0);
        end
        rst_n = 1'b0;
        tick();
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_glitch", 32'(glitch_cnt), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("midrst_rise_%0d", k), 32'(rise), 32'(k == 5));
            check($sformatf("midrst_glitch_%0d", k), 32'(glitch_cnt), 32'd0);
        end
        check("midrst_level_final", 32'(level), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, asynchronous, possibly bouncing single-bit input (button, switch, external strobe) into a clean, synchronous level for the edge and pulse detectors downstream. It contains a multi-flop synchronizer and a stable-count debounce filter. It also produces registered rise/fall strobes and a saturating count of rejected glitches. Its `level` output connects directly to the `a` input of the edge and pulse detector stage.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive mismatch cycles required to accept a change; legal range ≥ 1. 1 means no filtering.
- `GLITCH_W`, default 8: width of `glitch_cnt`.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-low reset; sampled on `clk` rising edge, `rst` = 0 resets.
- `a`  input  1  raw asynchronous input.
- `level`  output  1  debounced, synchronous level; registered.
- `rise`  output  1  one-cycle strobe when `level` goes 0→1; registered.
- `fall`  output  1  one-cycle strobe when `level` goes 1→0; registered.
- `glitch_cnt`  output  GLITCH_W  number of rejected transitions; saturating; registered.

## Operation
- **Synchronizer:** chain of `SYNC_STAGES` flops; `s` denotes the last stage. No logic is placed between the stages.
- **Debounce counter:** `cnt`, width clog2(DEBOUNCE_CYCLES)+1.
- Each edge while `rst` = 1:
  - If `s` != `level` and `cnt` == DEBOUNCE_CYCLES-1: `level` <= `s`; `rise` <= `s`; `fall` <= ~`s`; `cnt` <= 0.
  - If `s` != `level` otherwise: `cnt` <= `cnt`+1; `rise` = `fall` = 0.
  - If `s` == `level` and `cnt` != 0: glitch rejected. `cnt` <= 0 and `glitch_cnt` <= `glitch_cnt`+1, unless already all-ones, in which case it holds.
  - If `s` == `level` and `cnt` == 0: idle; `rise` = `fall` = 0.
- `rise` and `fall` are never both 1.
- Each strobe lasts exactly one cycle per accepted transition.
- `rise` is cycle-identical to what a posedge detector on `level` would produce one cycle later. Downstream stages must not double-detect.
- **Reset** (`rst` = 0 at an edge):
  - All synchronizer flops, `level`, `cnt`, `rise`, `fall` and `glitch_cnt` are set to 0.
  - Reset overrides everything, including mid-count and a strobe cycle.
  - Reset does not depend on the value of `a`.
- Once `level` changes, bouncing toward the old value needs another DEBOUNCE_CYCLES stable cycles to be accepted.

## Timing
- **Reset values:** `level` = 0, `rise` = 0, `fall` = 0, `glitch_cnt` = 0.
- **Acceptance latency:** let edge E be the first edge that samples a new stable `a`.
  - `level` and the strobe update at the output after edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges counting E.
  - Defaults: 6 edges.
- **Rejection:** a change of `a` that persists for fewer than DEBOUNCE_CYCLES sampled edges is rejected.
  - Applies to changes aligned to edges (synchronizer metastability aside).
  - `glitch_cnt` increments SYNC_STAGES edges after the first edge that samples `a` back at the old value.
- **Back-to-back:** a new opposite transition can be accepted no earlier than DEBOUNCE_CYCLES edges after the previous acceptance. Strobes are therefore separated by ≥ DEBOUNCE_CYCLES-1 idle cycles.
- **DEBOUNCE_CYCLES = 1:** `level` follows `s` with one cycle of delay, and `glitch_cnt` never increments.

## Test plan
All scenarios use the defaults (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=8) and drive `a` on `clk` edges.
- **Reset:** `rst` = 0 for 2 edges, `a` = 1 -> after the edges, `level` = 0, `rise` = 0, `fall` = 0, `glitch_cnt` = 0.
- **Clean rise:** `a` goes 0→1 at edge E and is held -> `rise` = 1 only in the cycle after edge E+5, `level` = 1 from then on, `fall` = 0 throughout.
- **Bounce:** `a` sequence 1,1,0,0,0,0,0,0 starting from `level` = 0 -> `level` stays 0, `rise` never asserts, `glitch_cnt` 0→1.
- **Clean fall:** `level` = 1, `a` held at 0 from edge E -> `fall` = 1 only in the cycle after edge E+5, `level` = 0.
- **Saturation:** 300 two-cycle pulses on `a`, each separated by 6 zero cycles -> `glitch_cnt` ends at 255 with no wrap, and `level` stays 0.
- **Reset mid-count:** `a` = 1 for 4 edges, then `rst` = 0 for one edge while `a` stays 1 -> no `rise` before reset; after `rst` returns to 1, `rise` comes exactly 6 edges later and `glitch_cnt` = 0.
